word_memory_sequencer: RTL
==========================

Name: word_memory_sequencer

Overview:
- Multi-beat load/store engine between the datapath (register files, ALU, address file) and the byte-wide data memory.
- Splits one WORD_W-bit access into BEATS = WORD_W/BYTE_W byte transfers at consecutive addresses and assembles read bytes into a word.
- Supports selectable endianness and a valid/ready request handshake.
- Successor to the fixed high/low-byte muxing in the current memory write path.

Parameters:
- WORD_W, 16, datapath word width; must be a multiple of BYTE_W.
- BYTE_W, 8, memory data width.
- ADDR_W, 16, memory address width.
- BEATS is derived as WORD_W/BYTE_W; legal values are 1, 2, 4 or 8.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req_Valid  in  1  request present.
- Req_Ready  out  1  sequencer can accept a request.
- Req_Write  in  1  1 = store, 0 = load.
- Req_BigEnd  in  1  1 = most significant byte at the lowest address.
- Req_Addr  in  ADDR_W  base byte address.
- Req_WData  in  WORD_W  store data.
- Rsp_Valid  out  1  one-cycle completion pulse.
- Rsp_RData  out  WORD_W  assembled load data; holds its value until the next load completes.
- Rsp_Error  out  1  misalignment flag, qualified by Rsp_Valid.
- Mem_Addr  out  ADDR_W  beat address.
- Mem_WData  out  BYTE_W  beat store byte.
- Mem_En  out  1  memory access enable, active-high.
- Mem_WR  out  1  1 = write, 0 = read.
- Mem_RData  in  BYTE_W  memory read data; combinational, valid in the same cycle as Mem_En=1 with Mem_WR=0.

Behaviour:
- Reset value of every output is 0: Req_Ready=0 while Reset is asserted, Rsp_*=0, Mem_*=0.
- State is IDLE after Reset deasserts.
- FSM states: IDLE, BEAT, RESP.
- IDLE:
  - Req_Ready=1.
  - A handshake occurs when Req_Valid && Req_Ready at a rising edge.
  - On handshake: latch Req_Write, Req_BigEnd, Req_Addr and Req_WData; clear the beat counter; go to BEAT.
- BEAT:
  - Req_Ready=0, Mem_En=1, Mem_WR equals the latched Write.
  - Mem_Addr = base + k, modulo 2^ADDR_W; wrap from all-ones to 0 is legal.
  - Byte lane for beat k is BEATS-1-k when BigEnd=1, and k when BigEnd=0.
  - Store: Mem_WData = WData lane.
  - Load: Mem_RData is written into that lane of the assembly register at the edge ending the beat.
  - After beat BEATS-1, go to RESP.
- RESP:
  - Rsp_Valid=1 for exactly one cycle, Mem_En=0.
  - Rsp_RData is updated for loads and unchanged for stores.
  - Next state is IDLE. There is no backpressure on the response.
- Latency: handshake at edge T → beats in cycles T+1..T+BEATS → Rsp_Valid in cycle T+BEATS+1 → Req_Ready again in T+BEATS+2.
- Throughput: one request per BEATS+2 cycles.
- Req_Valid while busy is ignored; the requester holds its request until Req_Ready.
- Request inputs are don't-care outside IDLE.
- BEATS=1: a single beat and no lane steering.
- Reset mid-operation:
  - All outputs go to 0 immediately (asynchronously) and the state goes to IDLE.
  - The partial access is abandoned with no Rsp_Valid.
  - Bytes already stored stay in memory.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- Defined:
  - A request with Req_Addr mod BEATS ≠ 0 goes IDLE → RESP directly with no Mem_En cycles.
  - Rsp_Valid=1 and Rsp_Error=1 one cycle after the handshake; Rsp_RData is unchanged.
  - Aligned requests behave as in Behaviour, with Rsp_Error=0.
- Undefined:
  - Rsp_Error is tied 0.
  - Misaligned requests perform BEATS normal beats with address wrap.

Decomposition:
- Shared package (word_mem_pkg) holds:
  - the state enum (IDLE, BEAT, RESP);
  - a BEATS derivation function and a lane-index function (beat, bigend, BEATS);
  - the legal-BEATS elaboration check.
- One sub-module is natural: byte_lane_select. It is a combinational BYTE_W slice of a WORD_W word selected by the lane index and is reused for store data; the sequencer itself owns the FSM, counter and assembly register.

Test Plan:
- WORD_W=16, little-endian store of 0xBEEF at 0x0040 → beat 1 writes 0xEF@0x0040, beat 2 writes 0xBE@0x0041. Rsp_Valid in cycle T+3 with Rsp_Error=0.
- Big-endian load from 0x0040 with memory 0x0040=0x12, 0x0041=0x34 → Rsp_RData=0x1234. The same access little-endian → 0x3412.
- WORD_W=32 load at 0xFFFE → Mem_Addr sequence FFFE, FFFF, 0000, 0001, with Req_Ready low for 5 cycles (T+1..T+5). Undefined macro: completes normally. Defined: misalignment causes no Mem_En and Rsp_Error=1 at T+1.
- Req_Valid held high through a load → second handshake exactly at T+BEATS+2. No Mem_En during RESP.
- Reset asserted mid-BEAT of a store → Mem_En=0 the same cycle, no Rsp_Valid, Req_Ready=1 the first cycle after release. The next load returns the correct data.
- Back-to-back store 0xA55A then load from the same address → Rsp_RData=0xA55A. Rsp_RData is unchanged by the intervening store response.

Source files
------------

// File: rtl/word_memory_sequencer_pkg.sv
// word_mem_pkg: shared FSM state type and beat/lane helpers for the word memory sequencer
package word_mem_pkg;

    typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

    function automatic int calc_beats(input int word_w, input int byte_w);
        return word_w / byte_w;
    endfunction

    function automatic bit beats_legal(input int word_w, input int byte_w);
        int b = word_w / byte_w;
        return (word_w % byte_w == 0) && (b == 1 || b == 2 || b == 4 || b == 8);
    endfunction

    function automatic logic [2:0] lane_idx(input logic [2:0] beat, input logic bigend, input int beats);
        return bigend ? 3'(beats - 1) - beat : beat;
    endfunction

endpackage

// File: rtl/word_memory_sequencer_if.sv
// word_memory_sequencer_if: request/response handshake and byte-wide memory bus of the sequencer
interface word_memory_sequencer_if #(
    parameter int WORD_W = 16,
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 16
);
    logic              Req_Valid;
    logic              Req_Ready;
    logic              Req_Write;
    logic              Req_BigEnd;
    logic [ADDR_W-1:0] Req_Addr;
    logic [WORD_W-1:0] Req_WData;
    logic              Rsp_Valid;
    logic [WORD_W-1:0] Rsp_RData;
    logic              Rsp_Error;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [BYTE_W-1:0] Mem_WData;
    logic              Mem_En;
    logic              Mem_WR;
    logic [BYTE_W-1:0] Mem_RData;

    modport slave (
        input  Req_Valid, Req_Write, Req_BigEnd, Req_Addr, Req_WData, Mem_RData,
        output Req_Ready, Rsp_Valid, Rsp_RData, Rsp_Error, Mem_Addr, Mem_WData, Mem_En, Mem_WR
    );

    modport master (
        output Req_Valid, Req_Write, Req_BigEnd, Req_Addr, Req_WData, Mem_RData,
        input  Req_Ready, Rsp_Valid, Rsp_RData, Rsp_Error, Mem_Addr, Mem_WData, Mem_En, Mem_WR
    );
endinterface

// File: rtl/word_memory_sequencer_byte_lane_select.sv
// byte_lane_select: picks one BYTE_W lane out of a WORD_W word
module byte_lane_select #(
    parameter int WORD_W = 16,
    parameter int BYTE_W = 8
) (
    input  logic [WORD_W-1:0] word_i,
    input  logic [2:0]        lane_i,
    output logic [BYTE_W-1:0] byte_o
);
    assign byte_o = BYTE_W'(word_i >> (BYTE_W * int'(lane_i)));
endmodule

// File: rtl/word_memory_sequencer.sv
// word_memory_sequencer: splits word loads/stores into byte beats; ALIGN_CHECK_EN rejects misaligned requests
module word_memory_sequencer
    import word_mem_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic Clock,
    input  logic Reset,
    word_memory_sequencer_if.slave bus
);
    localparam int BEATS = calc_beats(WORD_W, BYTE_W);

    if (!beats_legal(WORD_W, BYTE_W)) begin : g_bad_beats
        $error("word_memory_sequencer: WORD_W/BYTE_W must be 1, 2, 4 or 8");
    end

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              be_q, be_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic [2:0]        lane;
    logic              last;
    logic              mis;
    logic [BYTE_W-1:0] lane_byte;

    assign lane = lane_idx(cnt_q, be_q, BEATS);
    assign last = cnt_q == 3'(BEATS - 1);

`ifdef ALIGN_CHECK_EN
    assign mis = (bus.Req_Addr & ADDR_W'(BEATS - 1)) != '0;
`else
    assign mis = 1'b0;
`endif

    byte_lane_select #(.WORD_W(WORD_W), .BYTE_W(BYTE_W)) u_store_lane (
        .word_i(wdata_q),
        .lane_i(lane),
        .byte_o(lane_byte)
    );

    // next-state: latch request in IDLE, step beats and assemble load bytes in BEAT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        be_d    = be_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (bus.Req_Valid) begin
                wr_d    = bus.Req_Write;
                be_d    = bus.Req_BigEnd;
                addr_d  = bus.Req_Addr;
                wdata_d = bus.Req_WData;
                cnt_d   = '0;
                err_d   = mis;
                state_d = mis ? RESP : BEAT;
            end
            BEAT: begin
                if (!wr_q) asm_d[int'(lane)*BYTE_W +: BYTE_W] = bus.Mem_RData;
                cnt_d = cnt_q + 3'd1;
                if (last) begin
                    state_d = RESP;
                    rdata_d = wr_q ? rdata_q : asm_d;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            be_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
        end
    end

    // outputs decoded from state; everything idles at zero
    always_comb begin
        bus.Req_Ready = (state_q == IDLE) && !Reset;
        bus.Mem_En    = state_q == BEAT;
        bus.Mem_WR    = (state_q == BEAT) && wr_q;
        bus.Mem_Addr  = (state_q == BEAT) ? addr_q + ADDR_W'(cnt_q) : '0;
        bus.Mem_WData = (state_q == BEAT) ? lane_byte : '0;
        bus.Rsp_Valid = state_q == RESP;
        bus.Rsp_Error = (state_q == RESP) && err_q;
        bus.Rsp_RData = rdata_q;
    end
endmodule
